// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Holds default parameters, instruction field positions and the field decoder.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_RESET_PC = 0;

  localparam int unsigned OPCODE_LSB = 10;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned SRC_LSB    = 7;
  localparam int unsigned SRC_W      = 3;
  localparam int unsigned DST_LSB    = 4;
  localparam int unsigned DST_W      = 3;
  localparam int unsigned SHAMT_LSB  = 0;
  localparam int unsigned SHAMT_W    = 4;
  localparam int unsigned FIELD_W    = 16;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [SRC_W-1:0]    src;
    logic [DST_W-1:0]    dst;
    logic [SHAMT_W-1:0]  shamt;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [FIELD_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_LSB +: OPCODE_W];
    f.src    = instr[SRC_LSB    +: SRC_W];
    f.dst    = instr[DST_LSB    +: DST_W];
    f.shamt  = instr[SHAMT_LSB  +: SHAMT_W];
    return f;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory and downstream-pipeline signals of the fetch stage.
// master = fetch stage side, slave = memory/pipeline environment side.
interface fetch_if import fetch_pkg::*; #(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) ();

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                stall;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                out_valid;
  logic [INSTR_W-1:0]  out_instr;
  logic [ADDR_W-1:0]   out_pc;
  logic [OPCODE_W-1:0] opcode;
  logic [SRC_W-1:0]    src;
  logic [DST_W-1:0]    dst;
  logic [SHAMT_W-1:0]  shiftamount;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
           opcode, src, dst, shiftamount,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
           opcode, src, dst, shiftamount,
    output imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of (instruction, PC) entries with push/pop/flush and occupancy.
// Head outputs read zero while the queue is empty.
module fetch_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_c;
  logic              do_pop;
  logic              do_push;

  assign empty_c = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy update; flush behaves like reset.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      data_q[wr_q] <= data_i;
      pc_q[wr_q]   <= pc_i;
    end
  end

  assign head_data_o = empty_c ? '0 : data_q[rd_q];
  assign head_pc_o   = empty_c ? '0 : pc_q[rd_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-cycle-latency memory requests,
// prefetch queue and head-instruction field decode, with redirect flush.
module fetch_stage import fetch_pkg::*; #(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc;
  logic [OCC_W-1:0]   occupancy;
  logic               req_c;
  logic               valid_c;
  logic               push_c;
  logic               pop_c;
  instr_fields_t      fields_c;

  // Requests depend only on registered occupancy; in-flight slots count as used.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q);
  assign req_c     = rst_n && (occupancy < OCC_W'(DEPTH));
  assign valid_c   = (count != '0);
  assign pop_c     = valid_c && !bus.stall && !bus.redirect;
  assign push_c    = inflight_q && !bus.redirect;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = req_c;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect) begin
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
    end else if (req_c) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DATA_W (INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.redirect),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .data_i      (bus.imem_rdata),
    .pc_i        (inflight_pc_q),
    .head_data_o (head_data),
    .head_pc_o   (head_pc),
    .count_o     (count)
  );

  assign fields_c = decode_fields(head_data[FIELD_W-1:0]);

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = valid_c;
  assign bus.out_instr   = head_data;
  assign bus.out_pc      = head_pc;
  assign bus.opcode      = fields_c.opcode;
  assign bus.src         = fields_c.src;
  assign bus.dst         = fields_c.dst;
  assign bus.shiftamount = fields_c.shamt;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 16, PC and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction width; SHALL be >= 16.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; SHALL be a power of 2 and >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 imem_req  out  1  fetch request this cycle.
REQ-008 imem_addr  out  ADDR_W  word address of the request.
REQ-009 imem_rdata  in  INSTR_W  instruction data, valid in the cycle after the request.
REQ-010 stall  in  1  downstream not ready; head entry is held.
REQ-011 redirect  in  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  in  ADDR_W  target PC, sampled when redirect=1.
REQ-013 out_valid  out  1  head instruction presented.
REQ-014 out_instr  out  INSTR_W  head instruction.
REQ-015 out_pc  out  ADDR_W  PC of the head instruction.
REQ-016 opcode / src / dst / shiftamount  out  6/3/3/4  head fields: instr[15:10], [9:7], [6:4], [3:0].

Function
REQ-017 The PC register SHALL drive imem_addr; imem_req SHALL be derived only from registered state, never combinationally from stall or redirect.
REQ-018 imem_req SHALL be 1 iff (queue count + in-flight requests) < DEPTH; each accepted request SHALL advance PC by 1, modulo 2^ADDR_W.
REQ-019 Response data SHALL be written into the queue tail together with its PC at the end of the cycle after the request; first out_valid SHALL occur 2 cycles after the first request cycle.
REQ-020 out_valid SHALL be 1 iff the queue is non-empty; with out_valid=0, out_instr, out_pc and all fields SHALL read 0.
REQ-021 Pop SHALL occur when out_valid=1 and stall=0; push and pop in the same cycle SHALL leave the count unchanged.
REQ-022 Under sustained stall=0, DEPTH>=3, throughput SHALL be one instruction per cycle with consecutive PCs.
REQ-023 Under stall=1 the head entry SHALL stay stable; the queue SHALL fill to DEPTH, then imem_req SHALL drop to 0 without overflow.
REQ-024 On redirect=1: queue flushed, PC <= redirect_pc, and any response arriving in the following cycle discarded; the next cycle SHALL have out_valid=0, imem_req=1, imem_addr=redirect_pc.
REQ-025 redirect SHALL take priority over stall, over a pop, and over a push in the same cycle.
REQ-026 Back-to-back redirects SHALL each restart fetch; only the last target's instructions SHALL reach the output.

Reset
REQ-027 While rst_n=0 at a rising edge: queue empty, in-flight cleared, PC=RESET_PC, imem_req=0, out_valid=0, and all data outputs 0.
REQ-028 In the first cycle with rst_n=1, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard queued and in-flight instructions, with no output of stale data afterwards.

Structure
REQ-030 Shared package fetch_pkg SHALL hold field bit positions, field widths and default parameter constants.
REQ-031 The queue SHALL be a sub-module fetch_fifo (data+PC entries, push/pop/flush, count), instantiated once.

Verification
REQ-032 imem[0..2]=0x04F0,0x0560,0x14B0; release reset, stall=0 -> out_valid 2 cycles after first req; out_pc 0,1,2 on consecutive cycles; first opcode=1, src=1, dst=7, shiftamount=0.
REQ-033 stall=1 for 10 cycles from out_pc=0 -> queue holds 4, imem_req=0, out_pc stays 0; release -> out_pc 0,1,2,3,4 with no gap.
REQ-034 redirect=1, redirect_pc=0x0020, with 3 entries queued and 1 in flight -> next cycle out_valid=0, imem_addr=0x0020; next valid out_pc=0x0020; no PC 3..5 appears.
REQ-035 redirect=1 and stall=1 in the same cycle -> flush still happens; out_pc=redirect_pc at the next valid output.
REQ-036 redirect_pc=0xFFFF -> out_pc 0xFFFF, then 0x0000.
REQ-037 rst_n=0 for one cycle with queue full -> out_valid=0 at the next edge; first request after release at RESET_PC.
